// File: rtl/id_ex_pipeline_reg_if.sv
// Decode-to-execute bundle: ID-side fields entering the ID/EX register and the
// EX-side copies it presents to the execute stage.
interface id_ex_pipeline_reg_if #(
    parameter int DATA_W = 32
);
    // ID-side fields, driven by decode
    logic              regdst;
    logic              branch;
    logic              memread;
    logic              memtoreg;
    logic              memwrite;
    logic              alusrc;
    logic              regwrite;
    logic              cntrljalr;
    logic              cntrljald;
    logic [4:0]        ac;
    logic [1:0]        cntrljr;
    logic [25:0]       ID250Inst;
    logic [DATA_W-1:0] IDPCAddResult;
    logic [DATA_W-1:0] RD1Out;
    logic [DATA_W-1:0] RD2Out;
    logic [DATA_W-1:0] SignExOut;
    logic [4:0]        ID2016Inst;
    logic [4:0]        ID1511Inst;

    // EX-side fields, driven by the pipeline register
    logic              EXregdst;
    logic              EXbranch;
    logic              EXmemread;
    logic              EXmemtoreg;
    logic              EXmemwrite;
    logic              EXalusrc;
    logic              EXregwrite;
    logic              EXcntrljalr;
    logic              EXcntrljald;
    logic [4:0]        EXac;
    logic [1:0]        EXcntrljr;
    logic [25:0]       EX250Inst;
    logic [DATA_W-1:0] EXPCAddResult;
    logic [DATA_W-1:0] EXRD1;
    logic [DATA_W-1:0] EXRD2;
    logic [DATA_W-1:0] EXSignEx;
    logic [4:0]        EX2016Inst;
    logic [4:0]        EX1511Inst;

    // Decode side: drives ID fields, observes EX fields
    modport master (
        output regdst, branch, memread, memtoreg, memwrite, alusrc, regwrite,
               cntrljalr, cntrljald, ac, cntrljr, ID250Inst, IDPCAddResult,
               RD1Out, RD2Out, SignExOut, ID2016Inst, ID1511Inst,
        input  EXregdst, EXbranch, EXmemread, EXmemtoreg, EXmemwrite, EXalusrc,
               EXregwrite, EXcntrljalr, EXcntrljald, EXac, EXcntrljr, EX250Inst,
               EXPCAddResult, EXRD1, EXRD2, EXSignEx, EX2016Inst, EX1511Inst
    );

    // Pipeline register side: samples ID fields, drives EX fields
    modport slave (
        input  regdst, branch, memread, memtoreg, memwrite, alusrc, regwrite,
               cntrljalr, cntrljald, ac, cntrljr, ID250Inst, IDPCAddResult,
               RD1Out, RD2Out, SignExOut, ID2016Inst, ID1511Inst,
        output EXregdst, EXbranch, EXmemread, EXmemtoreg, EXmemwrite, EXalusrc,
               EXregwrite, EXcntrljalr, EXcntrljald, EXac, EXcntrljr, EX250Inst,
               EXPCAddResult, EXRD1, EXRD2, EXSignEx, EX2016Inst, EX1511Inst
    );
endinterface

// File: rtl/id_ex_pipeline_reg.sv
// ID/EX pipeline register: one-cycle capture of decode controls and operands,
// with synchronous reset, hold (Stall) and bubble insertion (Flush).
module id_ex_pipeline_reg #(
    parameter int DATA_W = 32
) (
    input logic              Clk,
    input logic              Reset,
    input logic              Stall,
    input logic              Flush,
    id_ex_pipeline_reg_if.slave bus
);

    typedef struct packed {
        logic [8:0]        ctrl;
        logic [4:0]        ac;
        logic [1:0]        cntrljr;
        logic [25:0]       inst250;
        logic [DATA_W-1:0] pc4;
        logic [DATA_W-1:0] rd1;
        logic [DATA_W-1:0] rd2;
        logic [DATA_W-1:0] signex;
        logic [4:0]        rt;
        logic [4:0]        rd;
    } stage_t;

    stage_t id_stage;
    stage_t stage_reg;
    stage_t stage_next;

    always_comb begin
        id_stage         = '0;
        id_stage.ctrl    = {bus.regdst, bus.branch, bus.memread, bus.memtoreg,
                            bus.memwrite, bus.alusrc, bus.regwrite,
                            bus.cntrljalr, bus.cntrljald};
        id_stage.ac      = bus.ac;
        id_stage.cntrljr = bus.cntrljr;
        id_stage.inst250 = bus.ID250Inst;
        id_stage.pc4     = bus.IDPCAddResult;
        id_stage.rd1     = bus.RD1Out;
        id_stage.rd2     = bus.RD2Out;
        id_stage.signex  = bus.SignExOut;
        id_stage.rt      = bus.ID2016Inst;
        id_stage.rd      = bus.ID1511Inst;
    end

    // Flush outranks Stall so a hazard bubble is inserted even while held
    always_comb begin
        stage_next = id_stage;
        if (Flush) begin
            stage_next = '0;
        end else if (Stall) begin
            stage_next = stage_reg;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            stage_reg <= '0;
        end else begin
            stage_reg <= stage_next;
        end
    end

    assign {bus.EXregdst, bus.EXbranch, bus.EXmemread, bus.EXmemtoreg,
            bus.EXmemwrite, bus.EXalusrc, bus.EXregwrite,
            bus.EXcntrljalr, bus.EXcntrljald} = stage_reg.ctrl;
    assign bus.EXac          = stage_reg.ac;
    assign bus.EXcntrljr     = stage_reg.cntrljr;
    assign bus.EX250Inst     = stage_reg.inst250;
    assign bus.EXPCAddResult = stage_reg.pc4;
    assign bus.EXRD1         = stage_reg.rd1;
    assign bus.EXRD2         = stage_reg.rd2;
    assign bus.EXSignEx      = stage_reg.signex;
    assign bus.EX2016Inst    = stage_reg.rt;
    assign bus.EX1511Inst    = stage_reg.rd;

endmodule

// File: tb/tb_id_ex_pipeline_reg.sv
// Directed bench for the ID/EX pipeline register: reset, load, stall, flush,
// pipelining and reset priority, all against hand-computed vectors.
module tb_id_ex_pipeline_reg;

    localparam int DATA_W = 32;
    localparam int VEC_W  = 9 + 5 + 2 + 26 + 4 * DATA_W + 5 + 5;

    // Field order: 9 controls (regdst..cntrljald), ac, cntrljr, 250Inst,
    // PC+4, RD1, RD2, SignEx, rt, rd
    localparam logic [VEC_W-1:0] S2 = {9'h1FF, 5'd7, 2'd3, 26'h3FFFFFF,
                                       32'd63, 32'd127, 32'd255, 32'd511,
                                       5'd7, 5'd15};
    localparam logic [VEC_W-1:0] DISTINCT = {9'b1_0110_1001, 5'h15, 2'b10,
                                             26'h2A55A5A, 32'hDEADBEEF,
                                             32'h01234567, 32'h89ABCDEF,
                                             32'hFFFF8000, 5'h13, 5'h0C};

    logic clk = 1'b0;
    logic reset;
    logic stall;
    logic flush;
    int   checks = 0;
    int   errors = 0;
    logic [VEC_W-1:0] ex_all;

    always #5 clk = ~clk;

    id_ex_pipeline_reg_if #(.DATA_W(DATA_W)) bus ();

    id_ex_pipeline_reg #(.DATA_W(DATA_W)) dut (
        .Clk   (clk),
        .Reset (reset),
        .Stall (stall),
        .Flush (flush),
        .bus   (bus.slave)
    );

    assign ex_all = {bus.EXregdst, bus.EXbranch, bus.EXmemread, bus.EXmemtoreg,
                     bus.EXmemwrite, bus.EXalusrc, bus.EXregwrite,
                     bus.EXcntrljalr, bus.EXcntrljald, bus.EXac, bus.EXcntrljr,
                     bus.EX250Inst, bus.EXPCAddResult, bus.EXRD1, bus.EXRD2,
                     bus.EXSignEx, bus.EX2016Inst, bus.EX1511Inst};

    task automatic drive(input logic [VEC_W-1:0] v);
        {bus.regdst, bus.branch, bus.memread, bus.memtoreg, bus.memwrite,
         bus.alusrc, bus.regwrite, bus.cntrljalr, bus.cntrljald, bus.ac,
         bus.cntrljr, bus.ID250Inst, bus.IDPCAddResult, bus.RD1Out, bus.RD2Out,
         bus.SignExOut, bus.ID2016Inst, bus.ID1511Inst} = v;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        drive(S2);
        reset = 1'b1; stall = 1'b0; flush = 1'b0;
        tick();
        checks++;
        if (ex_all !== '0) begin
            errors++;
            $display("FAIL reset_clear: got %h expected 0", ex_all);
        end
        $display("reset: outputs %h", ex_all);
        reset = 1'b0;
    endtask

    task automatic test_load();
        drive(S2);
        #2;
        checks++;
        if (ex_all !== '0) begin
            errors++;
            $display("FAIL load_before_edge: got %h expected 0", ex_all);
        end
        tick();
        checks++;
        if (ex_all !== S2) begin
            errors++;
            $display("FAIL load_after_edge: got %h expected %h", ex_all, S2);
        end
        checks++;
        if (bus.EXRD1 !== 32'd127 || bus.EX250Inst !== 26'h3FFFFFF || bus.EXac !== 5'd7) begin
            errors++;
            $display("FAIL load_fields: rd1=%0d inst=%h ac=%0d expected 127 3ffffff 7",
                     bus.EXRD1, bus.EX250Inst, bus.EXac);
        end
        $display("load: outputs %h", ex_all);
    endtask

    task automatic test_distinct();
        drive(DISTINCT);
        tick();
        checks++;
        if (ex_all !== DISTINCT) begin
            errors++;
            $display("FAIL distinct_load: got %h expected %h", ex_all, DISTINCT);
        end
        $display("distinct: outputs %h", ex_all);
        for (int k = 0; k < 9; k++) begin
            logic [VEC_W-1:0] v;
            v = '0;
            v[VEC_W-1-k] = 1'b1;
            drive(v);
            tick();
            checks++;
            if (ex_all !== v) begin
                errors++;
                $display("FAIL ctrl_walk_%0d: got %h expected %h", k, ex_all, v);
            end
            $display("ctrl_walk %0d: outputs %h", k, ex_all);
        end
    endtask

    task automatic test_stall();
        drive(S2);
        tick();
        stall = 1'b1;
        drive('0);
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (ex_all !== S2) begin
                errors++;
                $display("FAIL stall_hold_%0d: got %h expected %h", i, ex_all, S2);
            end
            $display("stall %0d: outputs %h", i, ex_all);
        end
        stall = 1'b0;
        #2;
        checks++;
        if (ex_all !== S2) begin
            errors++;
            $display("FAIL stall_release_before_edge: got %h expected %h", ex_all, S2);
        end
        tick();
        checks++;
        if (ex_all !== '0) begin
            errors++;
            $display("FAIL stall_release: got %h expected 0", ex_all);
        end
        $display("stall release: outputs %h", ex_all);
    endtask

    task automatic test_flush();
        drive(S2);
        tick();
        checks++;
        if (ex_all !== S2) begin
            errors++;
            $display("FAIL flush_preload: got %h expected %h", ex_all, S2);
        end
        flush = 1'b1; stall = 1'b1;
        tick();
        checks++;
        if (ex_all !== '0) begin
            errors++;
            $display("FAIL flush_bubble: got %h expected 0", ex_all);
        end
        $display("flush: outputs %h", ex_all);
        flush = 1'b0; stall = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [DATA_W-1:0] prev;
        prev = '0;
        drive(DISTINCT);
        tick();
        prev = bus.EXRD1;
        for (int i = 1; i <= 4; i++) begin
            logic [VEC_W-1:0] v;
            v = DISTINCT ^ {VEC_W{i[0]}};
            v[3*DATA_W+9:2*DATA_W+10] = i;
            drive(v);
            #2;
            checks++;
            if (bus.EXRD1 !== prev) begin
                errors++;
                $display("FAIL pipe_pre_%0d: got %0d expected %0d", i, bus.EXRD1, prev);
            end
            tick();
            checks++;
            if (bus.EXRD1 !== DATA_W'(i) || ex_all !== v) begin
                errors++;
                $display("FAIL pipe_%0d: rd1=%0d expected %0d all=%h expected %h",
                         i, bus.EXRD1, i, ex_all, v);
            end
            $display("pipe %0d: EXRD1=%0d", i, bus.EXRD1);
            prev = bus.EXRD1;
        end
    endtask

    task automatic test_reset_priority();
        drive(DISTINCT);
        tick();
        reset = 1'b1; stall = 1'b1; flush = 1'b0;
        drive(S2);
        tick();
        checks++;
        if (ex_all !== '0) begin
            errors++;
            $display("FAIL reset_over_stall: got %h expected 0", ex_all);
        end
        $display("reset priority: outputs %h", ex_all);
        reset = 1'b0; stall = 1'b0;
        tick();
        checks++;
        if (ex_all !== S2) begin
            errors++;
            $display("FAIL reload_after_reset: got %h expected %h", ex_all, S2);
        end
        reset = 1'b1; flush = 1'b1;
        drive(DISTINCT);
        tick();
        checks++;
        if (ex_all !== '0) begin
            errors++;
            $display("FAIL reset_over_flush: got %h expected 0", ex_all);
        end
        reset = 1'b0; flush = 1'b0;
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; flush = 1'b0;
        drive('0);
        test_reset();
        test_load();
        test_distinct();
        test_stall();
        test_flush();
        test_back_to_back();
        test_reset_priority();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
